// File: rtl/cic_pkg.sv
// cic_pkg
// Shared definitions for the dual-rail CIC decimator.
//   cic_acc_w() : accumulator width IN_W + N*R_LOG2 needed for lossless
//                 modular integration at gain R^N.
//   ACC_W, SH   : accumulator width and output shift at the default build
//                 (IN_W=16, OUT_W=16, N=3, R_LOG2=6).
//   acc_t       : signed accumulator word at the default build.
package cic_pkg;

  localparam int IN_W_DEF   = 16;
  localparam int OUT_W_DEF  = 16;
  localparam int N_DEF      = 3;
  localparam int R_LOG2_DEF = 6;

  function automatic int cic_acc_w(input int inW, input int n, input int rLog2);
    return inW + n * rLog2;
  endfunction

  localparam int ACC_W = cic_acc_w(IN_W_DEF, N_DEF, R_LOG2_DEF);
  localparam int SH    = ACC_W - OUT_W_DEF;

  typedef logic signed [ACC_W-1:0] acc_t;

endpackage

// File: rtl/cic_dec_rail.sv
// cic_dec_rail
// One CIC rail: N registered integrators at input rate, a capture register,
// N comb stages at decimated rate and the output scaling register.
// Configuration macro: CIC_ROUND_EN selects round-half-away-from-zero on the
// discarded bits; without it the output is an arithmetic-shift floor.
// Ports:
//   clk      in   sample clock
//   rst      in   synchronous reset, active-high
//   i_vld    in   sample accept; integrators advance only when high
//   i_stage  in   strobe pipeline: [0] capture, [1..N] comb k, [N+1] output
//   i_x      in   signed input sample
//   o_y      out  signed scaled decimated sample, held between strobes
module cic_dec_rail
  import cic_pkg::*;
#(
  parameter int IN_W   = IN_W_DEF,
  parameter int OUT_W  = OUT_W_DEF,
  parameter int N      = N_DEF,
  parameter int R_LOG2 = R_LOG2_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_vld,
  input  logic [N+1:0]            i_stage,
  input  logic signed [IN_W-1:0]  i_x,
  output logic signed [OUT_W-1:0] o_y
);

  localparam int RAIL_ACC_W = cic_acc_w(IN_W, N, R_LOG2);
  localparam int SHW        = RAIL_ACC_W - OUT_W;

  // The rounding logic reads a half bit and the bits below it.
  if (SHW < 2) begin : gShiftCheck
    $error("cic_dec_rail: output shift must be at least 2");
  end

  logic signed [RAIL_ACC_W-1:0] r_integ  [1:N];
  logic signed [RAIL_ACC_W-1:0] r_comb   [1:N];
  logic signed [RAIL_ACC_W-1:0] r_dly    [1:N];
  logic signed [RAIL_ACC_W-1:0] w_combIn [1:N];
  logic signed [RAIL_ACC_W-1:0] r_cap;
  logic signed [RAIL_ACC_W-1:0] w_xExt;
  logic signed [RAIL_ACC_W-1:0] w_y;
  logic        [OUT_W-1:0]      w_trunc;
  logic        [OUT_W-1:0]      w_res;
  logic signed [OUT_W-1:0]      r_out;

  assign w_xExt = {{(RAIL_ACC_W-IN_W){i_x[IN_W-1]}}, i_x};

  // Integrator cascade. Every stage reads the previous stage's old value, so
  // the last integrator trails the input by N-1 samples; wraparound is
  // harmless because the combs undo it modulo 2^ACC_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 1; k <= N; k++) r_integ[k] <= '0;
    end else if (i_vld) begin
      r_integ[1] <= r_integ[1] + w_xExt;
      for (int k = 2; k <= N; k++) r_integ[k] <= r_integ[k] + r_integ[k-1];
    end
  end

  // Comb stage inputs: the first comb sees the capture register, the rest
  // see the previous comb's result.
  always_comb begin
    w_combIn[1] = r_cap;
    for (int k = 2; k <= N; k++) w_combIn[k] = r_comb[k-1];
  end

  // Capture and comb pipeline. Each stage, including its delay register,
  // moves only while the decimation strobe is passing through it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cap <= '0;
      for (int k = 1; k <= N; k++) begin
        r_comb[k] <= '0;
        r_dly[k]  <= '0;
      end
    end else begin
      if (i_stage[0]) r_cap <= r_integ[N];
      for (int k = 1; k <= N; k++) begin
        if (i_stage[k]) begin
          r_comb[k] <= w_combIn[k] - r_dly[k];
          r_dly[k]  <= w_combIn[k];
        end
      end
    end
  end

  assign w_y     = r_comb[N];
  assign w_trunc = w_y[RAIL_ACC_W-1:SHW];

`ifdef CIC_ROUND_EN
  // Round half away from zero: positives carry on the half bit alone,
  // negatives only when the discarded part is strictly above one half.
  logic w_half;
  logic w_lowAny;
  logic w_carry;
  assign w_half   = w_y[SHW-1];
  assign w_lowAny = |w_y[SHW-2:0];
  assign w_carry  = w_half & (~w_y[RAIL_ACC_W-1] | w_lowAny);
  assign w_res    = w_trunc + {{(OUT_W-1){1'b0}}, w_carry};
`else
  // Floor: the discarded fraction is simply dropped.
  logic w_unusedFrac;
  assign w_unusedFrac = ^w_y[SHW-1:0];
  assign w_res        = w_trunc;
`endif

  // Output register loads when the strobe leaves the last comb.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out <= '0;
    end else if (i_stage[N+1]) begin
      r_out <= w_res;
    end
  end

  assign o_y = r_out;

endmodule

// File: rtl/cic_dec_iq.sv
// cic_dec_iq
// Dual-rail (I/Q) CIC decimator by R = 2^R_LOG2 with N stages, unity gain.
// Configuration macro: CIC_ROUND_EN (round-half-away output rounding; the
// default build truncates by arithmetic shift).
// Ports:
//   clk       in   sample clock
//   rst       in   synchronous reset, active-high
//   din_vld   in   input sample qualifier
//   i_in      in   signed I sample
//   q_in      in   signed Q sample
//   dout_vld  out  one-clock pulse per decimated output, N+2 clocks after
//                  the accept edge of the R-th sample of a frame
//   i_out     out  signed decimated I
//   q_out     out  signed decimated Q
module cic_dec_iq
  import cic_pkg::*;
#(
  parameter int IN_W   = IN_W_DEF,
  parameter int OUT_W  = OUT_W_DEF,
  parameter int N      = N_DEF,
  parameter int R_LOG2 = R_LOG2_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    din_vld,
  input  logic signed [IN_W-1:0]  i_in,
  input  logic signed [IN_W-1:0]  q_in,
  output logic                    dout_vld,
  output logic signed [OUT_W-1:0] i_out,
  output logic signed [OUT_W-1:0] q_out
);

  // Strobes must be at least two clocks apart for the comb pipeline.
  if (R_LOG2 < 1) begin : gRatioCheck
    $error("cic_dec_iq: decimation ratio must be at least 2");
  end

  logic [R_LOG2-1:0] r_cnt;
  logic              r_stb;
  logic [N:0]        r_pipe;
  logic [N+1:0]      w_stage;

  // Decimation counter over accepted samples; the accept of the last sample
  // of a frame raises the strobe for one clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_stb <= 1'b0;
    end else begin
      r_stb <= din_vld && (r_cnt == {R_LOG2{1'b1}});
      if (din_vld) r_cnt <= r_cnt + 1'b1;
    end
  end

  // Strobe delay line shared by both rails: capture, N combs, output.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pipe   <= '0;
      dout_vld <= 1'b0;
    end else begin
      r_pipe   <= {r_pipe[N-1:0], r_stb};
      dout_vld <= r_pipe[N];
    end
  end

  assign w_stage = {r_pipe, r_stb};

  cic_dec_rail #(
    .IN_W   (IN_W),
    .OUT_W  (OUT_W),
    .N      (N),
    .R_LOG2 (R_LOG2)
  ) uRailI (
    .clk     (clk),
    .rst     (rst),
    .i_vld   (din_vld),
    .i_stage (w_stage),
    .i_x     (i_in),
    .o_y     (i_out)
  );

  cic_dec_rail #(
    .IN_W   (IN_W),
    .OUT_W  (OUT_W),
    .N      (N),
    .R_LOG2 (R_LOG2)
  ) uRailQ (
    .clk     (clk),
    .rst     (rst),
    .i_vld   (din_vld),
    .i_stage (w_stage),
    .i_x     (q_in),
    .o_y     (q_out)
  );

endmodule

// File: tb/tb_cic_dec_iq.sv
// tb_cic_dec_iq
// Directed bench for cic_dec_iq at default parameters (N=3, R=64). Transient
// outputs are predicted from the CIC impulse response (three cascaded
// 64-tap boxcars); the registered integrator cascade adds N-1 samples delay.
// Define CIC_ROUND_EN for the bench too when building the rounding variant.
module tb_cic_dec_iq;

  localparam int R    = 64;
  localparam int HLEN = 190;
  localparam int LAT  = 5;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               din_vld = 1'b0;
  logic signed [15:0] i_in = '0;
  logic signed [15:0] q_in = '0;
  logic               dout_vld;
  logic signed [15:0] i_out;
  logic signed [15:0] q_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int h [HLEN];
  int xsI[$];
  int xsQ[$];
  int acceptCyc[$];
  logic signed [15:0] outI[$];
  logic signed [15:0] outQ[$];
  int outCyc[$];

  cic_dec_iq dut (
    .clk      (clk),
    .rst      (rst),
    .din_vld  (din_vld),
    .i_in     (i_in),
    .q_in     (q_in),
    .dout_vld (dout_vld),
    .i_out    (i_out),
    .q_out    (q_out)
  );

  // Clock and edge counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (dout_vld === 1'b1) begin
      outI.push_back(i_out);
      outQ.push_back(q_out);
      outCyc.push_back(cyc);
    end
  end

  // Expected k-th output (1-based) from convolution with the CIC kernel
  function automatic logic signed [15:0] expOut(input int k, input bit isQ);
    longint acc = 0;
    longint qv;
    longint f;
    int n = R * k - 3;
    for (int j = 0; j < HLEN; j++) begin
      int idx = n - j;
      if (idx >= 0) acc += longint'(h[j]) * longint'(isQ ? xsQ[idx] : xsI[idx]);
    end
    qv = acc >>> 18;
    f  = acc & 64'h3FFFF;
`ifdef CIC_ROUND_EN
    if (acc >= 0) begin
      if (f >= 131072) qv = qv + 1;
    end else begin
      if (f > 131072) qv = qv + 1;
    end
`endif
    return qv[15:0];
  endfunction

  task automatic applyStimulus(input bit vld, input int iv, input int qv);
    @(negedge clk);
    din_vld = vld;
    i_in    = 16'(iv);
    q_in    = 16'(qv);
    if (vld) begin
      xsI.push_back(iv);
      xsQ.push_back(qv);
      acceptCyc.push_back(cyc + 1);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 0, 0);
  endtask

  task automatic doReset(input bit vldDuringReset);
    @(negedge clk);
    rst     = 1'b1;
    din_vld = vldDuringReset;
    @(negedge clk);
    rst     = 1'b0;
    din_vld = 1'b0;
    xsI.delete(); xsQ.delete(); acceptCyc.delete();
    outI.delete(); outQ.delete(); outCyc.delete();
  endtask

  task automatic test_reset();
    doReset(1'b1);
    checks++;
    if (dout_vld !== 1'b0) begin errors++; $display("[TB] FAIL reset_vld: got %b expected 0", dout_vld); end
    checks++;
    if (i_out !== 16'sd0) begin errors++; $display("[TB] FAIL reset_i: got %0d expected 0", i_out); end
    checks++;
    if (q_out !== 16'sd0) begin errors++; $display("[TB] FAIL reset_q: got %0d expected 0", q_out); end
  endtask

  // Constant input, back-to-back valid
  task automatic test_constant();
    doReset(1'b0);
    for (int s = 0; s < 6 * R; s++) applyStimulus(1'b1, 1000, -1000);
    idle(12);
    checks++;
    if (outI.size() != 6) begin errors++; $display("[TB] FAIL const_count: got %0d expected 6", outI.size()); end
    for (int k = 1; k <= outI.size() && k <= 6; k++) begin
      logic signed [15:0] eI, eQ;
      eI = (k >= 4) ? 16'sd1000 : expOut(k, 1'b0);
      eQ = (k >= 4) ? -16'sd1000 : expOut(k, 1'b1);
      checks++;
      if (outI[k-1] !== eI) begin errors++; $display("[TB] FAIL const_i[%0d]: got %0d expected %0d", k, outI[k-1], eI); end
      checks++;
      if (outQ[k-1] !== eQ) begin errors++; $display("[TB] FAIL const_q[%0d]: got %0d expected %0d", k, outQ[k-1], eQ); end
      if (k >= 2) begin
        checks++;
        if (outCyc[k-1] - outCyc[k-2] != R) begin
          errors++; $display("[TB] FAIL const_spacing[%0d]: got %0d expected %0d", k, outCyc[k-1] - outCyc[k-2], R);
        end
      end
    end
  endtask

  // din_vld toggling every clock
  task automatic test_gapped();
    doReset(1'b0);
    for (int s = 0; s < 10 * R; s++) begin
      applyStimulus(1'b1, 500, -7);
      applyStimulus(1'b0, 0, 0);
    end
    idle(12);
    checks++;
    if (outI.size() != 10) begin errors++; $display("[TB] FAIL gap_count: got %0d expected 10", outI.size()); end
    for (int k = 1; k <= outI.size() && k <= 10; k++) begin
      checks++;
      if (outI[k-1] !== expOut(k, 1'b0)) begin errors++; $display("[TB] FAIL gap_i[%0d]: got %0d expected %0d", k, outI[k-1], expOut(k, 1'b0)); end
      checks++;
      if (outQ[k-1] !== expOut(k, 1'b1)) begin errors++; $display("[TB] FAIL gap_q[%0d]: got %0d expected %0d", k, outQ[k-1], expOut(k, 1'b1)); end
      if (k >= 2) begin
        checks++;
        if (outCyc[k-1] - outCyc[k-2] != 2 * R) begin
          errors++; $display("[TB] FAIL gap_spacing[%0d]: got %0d expected %0d", k, outCyc[k-1] - outCyc[k-2], 2 * R);
        end
      end
    end
  endtask

  // Full-scale input long enough to wrap every integrator
  task automatic test_wrap();
    doReset(1'b0);
    for (int s = 0; s < 20000; s++) applyStimulus(1'b1, -32768, 32767);
    idle(12);
    checks++;
    if (outI.size() != 312) begin errors++; $display("[TB] FAIL wrap_count: got %0d expected 312", outI.size()); end
    for (int k = 4; k <= outI.size(); k++) begin
      checks++;
      if (outI[k-1] !== -16'sd32768) begin errors++; $display("[TB] FAIL wrap_i[%0d]: got %0d expected -32768", k, outI[k-1]); end
      checks++;
      if (outQ[k-1] !== 16'sd32767) begin errors++; $display("[TB] FAIL wrap_q[%0d]: got %0d expected 32767", k, outQ[k-1]); end
    end
  endtask

  // Reset after 40 of 64 samples discards the partial frame
  task automatic test_reset_midframe();
    doReset(1'b0);
    for (int s = 0; s < 40; s++) applyStimulus(1'b1, 300, -300);
    doReset(1'b1);
    for (int s = 0; s < R; s++) applyStimulus(1'b1, 300, -300);
    idle(12);
    checks++;
    if (outI.size() != 1) begin errors++; $display("[TB] FAIL midrst_count: got %0d expected 1", outI.size()); end
    if (outI.size() >= 1) begin
      checks++;
      if (outCyc[0] - acceptCyc[R-1] != LAT) begin
        errors++; $display("[TB] FAIL midrst_latency: got %0d expected %0d", outCyc[0] - acceptCyc[R-1], LAT);
      end
      checks++;
      if (outI[0] !== expOut(1, 1'b0)) begin errors++; $display("[TB] FAIL midrst_i: got %0d expected %0d", outI[0], expOut(1, 1'b0)); end
      checks++;
      if (outQ[0] !== expOut(1, 1'b1)) begin errors++; $display("[TB] FAIL midrst_q: got %0d expected %0d", outQ[0], expOut(1, 1'b1)); end
    end
  endtask

  // Settled 1 / -1 stepping to 2 / -2 mid-frame: transients exercise rounding
  task automatic test_step();
    doReset(1'b0);
    for (int s = 0; s < 4 * R + 32; s++) applyStimulus(1'b1, 1, -1);
    for (int s = 0; s < 6 * R - 32; s++) applyStimulus(1'b1, 2, -2);
    idle(12);
    checks++;
    if (outI.size() != 10) begin errors++; $display("[TB] FAIL step_count: got %0d expected 10", outI.size()); end
    for (int k = 1; k <= outI.size() && k <= 10; k++) begin
      checks++;
      if (outI[k-1] !== expOut(k, 1'b0)) begin errors++; $display("[TB] FAIL step_i[%0d]: got %0d expected %0d", k, outI[k-1], expOut(k, 1'b0)); end
      checks++;
      if (outQ[k-1] !== expOut(k, 1'b1)) begin errors++; $display("[TB] FAIL step_q[%0d]: got %0d expected %0d", k, outQ[k-1], expOut(k, 1'b1)); end
    end
  endtask

  // Latency from the 64th accept edge with irregular input gaps
  task automatic test_latency();
    doReset(1'b0);
    for (int s = 0; s < R; s++) begin
      if (s % 5 == 0) applyStimulus(1'b0, 0, 0);
      applyStimulus(1'b1, 12345 - 300 * s, -200 * s);
    end
    idle(12);
    checks++;
    if (outI.size() != 1) begin errors++; $display("[TB] FAIL lat_pulses: got %0d expected 1", outI.size()); end
    if (outI.size() >= 1) begin
      checks++;
      if (outCyc[0] - acceptCyc[R-1] != LAT) begin
        errors++; $display("[TB] FAIL lat_clocks: got %0d expected %0d", outCyc[0] - acceptCyc[R-1], LAT);
      end
      checks++;
      if (outI[0] !== expOut(1, 1'b0)) begin errors++; $display("[TB] FAIL lat_i: got %0d expected %0d", outI[0], expOut(1, 1'b0)); end
      checks++;
      if (outQ[0] !== expOut(1, 1'b1)) begin errors++; $display("[TB] FAIL lat_q: got %0d expected %0d", outQ[0], expOut(1, 1'b1)); end
    end
  endtask

  // Build the kernel, then run every scenario in order
  initial begin
    int b2 [127];
    for (int n = 0; n < 127; n++) begin
      b2[n] = 0;
      for (int a = 0; a < R; a++) if (n - a >= 0 && n - a < R) b2[n] += 1;
    end
    for (int n = 0; n < HLEN; n++) begin
      h[n] = 0;
      for (int m = 0; m < 127; m++) if (n - m >= 0 && n - m < R) h[n] += b2[m];
    end
    $display("[TB] starting");
    test_reset();
    test_constant();
    test_gapped();
    test_wrap();
    test_reset_midframe();
    test_step();
    test_latency();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
